// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared FSM encoding, config address map and period constants for pwm_seq_ctrl
package pwm_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam int PERIOD_RST = 100;
  localparam int PERIOD_MIN = 2;
endpackage

// File: rtl/pwm_ramp_step.sv
// pwm_ramp_step: moves a duty value toward its target by at most STEP without overshoot
module pwm_ramp_step #(
  parameter int CW = 7,
  parameter int STEP = 1
) (
  input  logic [CW-1:0] act,
  input  logic [CW-1:0] tgt,
  output logic [CW-1:0] nxt
);
  // one extra bit so a STEP wider than the duty range saturates instead of truncating
  localparam logic [CW:0] S = (STEP >= 2**CW) ? (CW+1)'(2**CW) : (CW+1)'(STEP);
  logic up;
  logic [CW-1:0] diff, delta;
  always_comb begin
    up = tgt > act;
    diff = up ? tgt - act : act - tgt;
    delta = ({1'b0, diff} < S) ? diff : S[CW-1:0];
    nxt = up ? act + delta : act - delta;
  end
endmodule

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: multi-channel PWM sequencer with soft-start ramp and period-boundary config updates
module pwm_seq_ctrl #(
  parameter int N_CH = 4,
  parameter int CW = 7,
  parameter int STEP = 1,
  parameter int PERIOD_RST = pwm_ctrl_pkg::PERIOD_RST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [2:0]      cfg_addr,
  input  logic [CW-1:0]   cfg_data,
  output logic [N_CH-1:0] pwm_out,
  output logic            period_start,
  output logic            busy
);
  import pwm_ctrl_pkg::*;
  localparam logic [CW-1:0] PRST = CW'(PERIOD_RST);
  localparam logic [CW-1:0] PMIN = CW'(PERIOD_MIN);
  state_t state, state_nx;
  logic [CW-1:0] cntr, period_q, period_sh;
  logic [CW-1:0] duty_tgt [N_CH];
  logic [CW-1:0] duty_act [N_CH];
  logic [CW-1:0] duty_nx [N_CH];
  logic [N_CH-1:0] pwm_nx;
  logic pend;

  assign pend = (state != IDLE) && (cntr == period_q - CW'(1));
  assign cfg_ready = rst_n;
  assign busy = state != IDLE;
  assign period_start = (state == RUN) && (cntr == '0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // STOP only leaves at a period end so a run is never cut short
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (en ? RUN : IDLE) :
               (state == RUN)  ? (en ? RUN : STOP) :
               pend            ? (en ? RUN : IDLE) : STOP;
  end

  // compare against next state so outputs drop on the very first IDLE cycle
  always_comb begin
    pwm_nx = '0;
    for (int i = 0; i < N_CH; i++) pwm_nx[i] = (state_nx != IDLE) && (cntr < duty_act[i]);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_ramp_step #(.CW(CW), .STEP(STEP)) u_step (
      .act(duty_act[g]),
      .tgt(duty_tgt[g]),
      .nxt(duty_nx[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntr <= '0;
      period_q <= PRST;
      period_sh <= PRST;
      pwm_out <= '0;
      for (int i = 0; i < N_CH; i++) begin
        duty_tgt[i] <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      cntr <= (state == IDLE || pend) ? '0 : cntr + CW'(1);
      pwm_out <= pwm_nx;
      if (pend) period_q <= period_sh;
      if (cfg_valid && cfg_addr == ADDR_PERIOD) period_sh <= (cfg_data < PMIN) ? PMIN : cfg_data;
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_valid && cfg_addr == 3'(i)) duty_tgt[i] <= cfg_data;
        if (pend) duty_act[i] <= (state_nx == IDLE) ? '0 : duty_nx[i];
      end
    end
  end
endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb_pwm_seq_ctrl: table-driven checks of per-period high times plus hand sequences for boundary cases
module tb_pwm_seq_ctrl;
  typedef struct {
    bit sel;
    bit wr;
    logic [2:0] a;
    logic [6:0] d;
    int p;
    logic [3:0][7:0] hi;
  } vec_t;

  logic clk = 0, rst_n = 0, en = 0, cfg_valid = 0;
  logic [2:0] cfg_addr = '0;
  logic [6:0] cfg_data = '0;
  logic [3:0] pwm0, pwm1, pw;
  logic ps0, ps1, bz0, bz1, rdy0, rdy1, ps, bz;
  bit sel;
  int checks = 0, failures = 0;
  vec_t tbl [21];

  always #5 clk = ~clk;

  pwm_seq_ctrl #(.N_CH(4), .CW(7), .STEP(1), .PERIOD_RST(100)) u_slow (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(rdy0),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pwm_out(pwm0), .period_start(ps0), .busy(bz0)
  );
  pwm_seq_ctrl #(.N_CH(4), .CW(7), .STEP(100), .PERIOD_RST(100)) u_fast (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(rdy1),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pwm_out(pwm1), .period_start(ps1), .busy(bz1)
  );

  assign pw = sel ? pwm1 : pwm0;
  assign ps = sel ? ps1 : ps0;
  assign bz = sel ? bz1 : bz0;

  function automatic vec_t mk(bit s, bit w, int a, int d, int p, int h0, int h1, int h2, int h3);
    vec_t v;
    v.sel = s; v.wr = w; v.a = 3'(a); v.d = 7'(d); v.p = p;
    v.hi = {8'(h3), 8'(h2), 8'(h1), 8'(h0)};
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; cfg_valid = 0; cfg_addr = '0; cfg_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_pwm_slow", pwm0, 0); chk("rst_pwm_fast", pwm1, 0);
    chk("rst_ps_slow", ps0, 0);   chk("rst_ps_fast", ps1, 0);
    chk("rst_busy_slow", bz0, 0); chk("rst_busy_fast", bz1, 0);
    chk("rst_ready_slow", rdy0, 0); chk("rst_ready_fast", rdy1, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", rdy0 & rdy1, 1);
  endtask

  task automatic wr(input int a, input int d);
    cfg_valid = 1; cfg_addr = 3'(a); cfg_data = 7'(d);
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic wait_ps(input string name);
    int n = 0;
    while (!ps && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, ps, 1);
  endtask

  task automatic period_len(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ps && n < 300);
  endtask

  task automatic run_row(input int r);
    int cnt [4];
    sel = tbl[r].sel;
    wait_ps($sformatf("row%0d_sync", r));
    if (tbl[r].wr) begin
      cfg_valid = 1; cfg_addr = tbl[r].a; cfg_data = tbl[r].d;
    end
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int k = 0; k < tbl[r].p; k++) begin
      @(negedge clk);
      cfg_valid = 0;
      for (int c = 0; c < 4; c++) cnt[c] += int'(pw[c]);
    end
    for (int c = 0; c < 4; c++) chk($sformatf("row%0d_ch%0d_high", r, c), cnt[c], int'(tbl[r].hi[c]));
    chk($sformatf("row%0d_period_len", r), ps, 1);
  endtask

  initial begin
    int n, psc;
    // fast instance: reset defaults, then extreme duties
    tbl[0]  = mk(1, 0, 0, 0,   100, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0,   100, 25, 50, 75, 95);
    tbl[2]  = mk(1, 1, 0, 0,   100, 25, 50, 75, 95);
    tbl[3]  = mk(1, 1, 1, 127, 100, 0, 50, 75, 95);
    tbl[4]  = mk(1, 1, 4, 10,  100, 0, 100, 75, 95);
    tbl[5]  = mk(1, 0, 0, 0,   10, 0, 10, 10, 10);
    tbl[6]  = mk(1, 0, 0, 0,   10, 0, 10, 10, 10);
    // slow instance: STEP=1 ramp up and down
    tbl[7]  = mk(0, 0, 0, 0,   100, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0,   10, 1, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0,   10, 2, 0, 2, 0);
    tbl[10] = mk(0, 0, 0, 0,   10, 3, 0, 2, 0);
    tbl[11] = mk(0, 1, 0, 1,   10, 3, 0, 2, 0);
    tbl[12] = mk(0, 0, 0, 0,   10, 2, 0, 2, 0);
    tbl[13] = mk(0, 0, 0, 0,   10, 1, 0, 2, 0);
    tbl[14] = mk(0, 0, 0, 0,   10, 1, 0, 2, 0);
    // slow instance: stop then soft restart
    tbl[15] = mk(0, 0, 0, 0,   100, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0,   10, 1, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0,   10, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0,   10, 1, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0,   10, 2, 0, 0, 0);
    // fast instance after a mid-run reset
    tbl[20] = mk(1, 0, 0, 0,   100, 0, 0, 0, 0);

    do_reset();
    wr(0, 25); wr(1, 50); wr(2, 75); wr(3, 95);
    en = 1;
    for (int r = 0; r <= 6; r++) run_row(r);

    do_reset();
    wr(4, 10); wr(0, 3); wr(2, 2);
    en = 1;
    for (int r = 7; r <= 14; r++) run_row(r);
    repeat (9) @(negedge clk);
    wr(4, 20);
    chk("bnd_ps_after_write", ps0, 1);
    period_len(n); chk("bnd_old_len", n, 10);
    period_len(n); chk("bnd_new_len", n, 20);
    wr(4, 0);
    period_len(n); chk("p0_current_len", n, 19);
    period_len(n); chk("p0_min_len", n, 2);
    period_len(n); chk("p0_min_len_again", n, 2);

    do_reset();
    wr(4, 10); wr(0, 3);
    en = 1;
    run_row(15);
    run_row(16);
    repeat (5) @(negedge clk);
    en = 0;
    n = 0; psc = 0;
    do begin
      @(negedge clk);
      n++;
      psc += int'(ps0);
    end while (bz0 && n < 50);
    chk("stop_tail_cycles", n, 5);
    chk("stop_no_ps", psc, 0);
    chk("idle_pwm", pwm0, 0);
    chk("idle_busy", bz0, 0);
    en = 1;
    for (int r = 17; r <= 19; r++) run_row(r);

    do_reset();
    sel = 1;
    wr(0, 127);
    en = 1;
    wait_ps("rmid_sync");
    repeat (100) @(negedge clk);
    repeat (37) @(negedge clk);
    chk("rmid_pwm_before", pwm1[0], 1);
    chk("rmid_busy_before", bz1, 1);
    #2 rst_n = 0;
    #1;
    chk("rmid_pwm_now", pwm1, 0);
    chk("rmid_busy_now", bz1, 0);
    chk("rmid_ready_now", rdy1, 0);
    en = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rmid_idle_busy", bz1, 0);
    en = 1;
    @(negedge clk);
    chk("rmid_first_ps", ps1, 1);
    run_row(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_seq_ctrl.md
PWM_SEQ_CTRL -- requirements
Module: pwm_seq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- N_CH, 4, number of PWM channels
- CW, 7, counter/duty/period width in bits
- STEP, 1, maximum duty change per channel per period (soft-start ramp)
- PERIOD_RST, 100, period value after reset
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 en  input  1  level run request.
REQ-005 cfg_valid  input  1  configuration write request.
REQ-006 cfg_ready  output  1  configuration write accepted when high with cfg_valid.
REQ-007 cfg_addr  input  3  0..N_CH-1 selects a channel duty target; 4 selects period; 5..7 are ignored but still accepted.
REQ-008 cfg_data  input  CW  value written.
REQ-009 pwm_out  output  N_CH  registered PWM outputs.
REQ-010 period_start  output  1  one-cycle pulse on the first cycle of every RUN period.
REQ-011 busy  output  1  high in RUN and STOP.

Function
REQ-012 FSM states SHALL be IDLE, RUN and STOP.
- IDLE->RUN when en=1, with cntr=0.
- RUN->STOP when en=0.
- STOP->RUN at period end if en=1, else STOP->IDLE at period end.
REQ-013 In RUN/STOP, cntr SHALL count 0..period_q-1, then wrap to 0 (period end = cntr==period_q-1); cntr SHALL hold 0 in IDLE.
REQ-014 pwm_out[i] SHALL be registered (cntr < duty_act[i]), giving 1-cycle latency from cntr; pwm_out SHALL be 0 in IDLE and on the cycle after entering IDLE.
- duty_act=0 SHALL give constant low.
- duty_act>=period_q SHALL give constant high for the whole period.
REQ-015 cfg_ready SHALL be 1 whenever rst_n=1; writes SHALL land in shadow registers duty_tgt[i] or period_sh in the accepting cycle.
REQ-016 period_sh writes of 0 or 1 SHALL be stored as 2.
REQ-017 At each period end, period_q SHALL load period_sh.
REQ-018 At each period end, every duty_act[i] SHALL move toward duty_tgt[i] by min(STEP, |difference|), with no overshoot and unsigned CW-bit arithmetic with no wrap.
REQ-019 A write accepted on the period-end cycle SHALL NOT affect that boundary; it applies at the next period end.
REQ-020 Entering IDLE SHALL clear all duty_act to 0, so every start soft-ramps from 0; duty_tgt and period_sh SHALL be retained.
REQ-021 period_start SHALL assert on the cycle cntr==0 in RUN, including the first cycle after IDLE->RUN; it SHALL NOT assert in STOP or IDLE.
REQ-022 en toggling within a period SHALL NOT truncate the period; only period end changes state from STOP.

Reset
REQ-023 On rst_n=0, regardless of clk, the block SHALL set:
- state=IDLE, cntr=0, pwm_out=0, period_start=0, busy=0, cfg_ready=0
- duty_tgt=0, duty_act=0, period_sh=period_q=PERIOD_RST
REQ-024 Reset mid-period SHALL take effect immediately; the first RUN after release SHALL start at cntr=0.

Structure
REQ-025 A shared package pwm_ctrl_pkg SHALL hold:
- the FSM state enum
- cfg_addr encodings (ADDR_PERIOD=4)
- PERIOD_RST
- the minimum period constant 2
REQ-026 One sub-module, pwm_ramp_step, SHALL implement the per-channel saturating step of duty_act toward duty_tgt; the top SHALL instantiate it N_CH times.

Verification
REQ-027 Reset defaults test: reset, write duty 25/50/75/95 to ch0..3 while en=0, then raise en with STEP=100 -> the second period onward shows high times of 25/50/75/95 cycles in a 100-cycle period, and period_start every 100 cycles.
REQ-028 STEP=1 ramp test: target 3, period 10 -> ch0 high time 0,1,2,3,3... cycles in successive periods; a later target 1 ramps down 2,1,1.
REQ-029 Boundary write test: write period=20 exactly on a period-end cycle -> the next period is still the old length and the following one is 20; write period=0 -> the period becomes 2.
REQ-030 Stop test: drop en at cntr=5 of a period of 10 -> outputs continue to cntr=9, then IDLE with pwm_out=0 and busy=0; re-raise en -> soft-start from duty 0.
REQ-031 Extreme duty test: duty 0 -> constant low; duty 127 with period 10 -> constant high.
REQ-032 Reset mid-run test: assert rst_n=0 at cntr=37 -> pwm_out=0 immediately and state=IDLE; after release, period=100 and duties 0.
